// File: rtl/uart_tx_cts.sv
// rtl/uart_tx_cts.sv - UART transmitter with holding buffer; UART_TX_CTS_FLOW_EN gates frame start on cts_n
module uart_tx_cts #(
  parameter int DIV_W           = 16,
  parameter int CTS_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_even,
  input  logic             stop_bits,
  input  logic             cts_n,
  output logic             uart_tx,
  output logic             tx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  state_t           state;
  logic             hold_full;
  logic [7:0]       hold_data;
  logic             cts_ok;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_r;
  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [3:0]       nbits_r;
  logic             par_en_r;
  logic             par_bit_r;
  logic             stop2_r;
  logic             tx_line;
  logic             busy_r;

  logic [DIV_W-1:0] div_eff;
  logic [7:0]       data_mask;
  logic             new_par;
  logic             bit_end;
  logic             last_stop;
  logic             load;

`ifdef UART_TX_CTS_FLOW_EN
  logic [CTS_SYNC_STAGES-1:0] cts_sync;

  // Bring the asynchronous cts_n into the clk domain; resets to "not clear"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cts_sync <= '1;
    else       cts_sync <= {cts_sync[CTS_SYNC_STAGES-2:0], cts_n};
  end

  assign cts_ok = ~cts_sync[CTS_SYNC_STAGES-1];
`else
  localparam int unused_sync_stages = CTS_SYNC_STAGES;
  logic unused_cts_n;
  assign unused_cts_n = cts_n;
  assign cts_ok       = 1'b1;
`endif

  // Frame-start decision, live config decode and bit-boundary detection
  always_comb begin
    div_eff   = (baud_div == '0) ? DIV_ONE : baud_div;
    data_mask = 8'hFF >> (2'd3 - data_bits);
    new_par   = parity_even ? ^(hold_data & data_mask) : ~(^(hold_data & data_mask));
    bit_end   = (cnt == '0);
    last_stop = bit_end && (((state == STOP1) && !stop2_r) || (state == STOP2));
    load      = hold_full && cts_ok && ((state == IDLE) || last_stop);
  end

  // One-entry holding buffer between the handshake and the shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  // Frame sequencer: latches config at frame start and walks start/data/parity/stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_line   <= 1'b1;
      busy_r    <= 1'b0;
      cnt       <= '0;
      div_r     <= DIV_ONE;
      shreg     <= 8'h00;
      bit_cnt   <= 4'd0;
      nbits_r   <= 4'd8;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
    end else if (load) begin
      state     <= START;
      tx_line   <= 1'b0;
      busy_r    <= 1'b1;
      cnt       <= div_eff - DIV_ONE;
      div_r     <= div_eff;
      shreg     <= hold_data;
      bit_cnt   <= 4'd0;
      nbits_r   <= {2'b00, data_bits} + 4'd5;
      par_en_r  <= parity_en;
      par_bit_r <= new_par;
      stop2_r   <= stop_bits;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt <= cnt - DIV_ONE;
      end else begin
        cnt <= div_r - DIV_ONE;
        case (state)
          START: begin
            state   <= DATA;
            tx_line <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= 4'd1;
          end
          DATA: begin
            if (bit_cnt == nbits_r) begin
              if (par_en_r) begin
                state   <= PARITY;
                tx_line <= par_bit_r;
              end else begin
                state   <= STOP1;
                tx_line <= 1'b1;
              end
            end else begin
              tx_line <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PARITY: begin
            state   <= STOP1;
            tx_line <= 1'b1;
          end
          STOP1: begin
            tx_line <= 1'b1;
            if (stop2_r) begin
              state <= STOP2;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
          STOP2: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready = ~hold_full;
  assign uart_tx  = tx_line;
  assign tx_busy  = busy_r;

endmodule

// File: tb/tb_uart_tx_cts.sv
// tb/tb_uart_tx_cts.sv - randomized self-checking bench for uart_tx_cts against a bit-list frame model
module tb_uart_tx_cts;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  data_bits = 2'b11;
  logic        parity_en = 1'b0;
  logic        parity_even = 1'b0;
  logic        stop_bits = 1'b0;
  logic        cts_n = 1'b0;
  logic        uart_tx;
  logic        tx_busy;

  int n_checks = 0;
  int n_pass = 0;

  uart_tx_cts #(.DIV_W(16), .CTS_SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .baud_div(baud_div), .data_bits(data_bits), .parity_en(parity_en), .parity_even(parity_even),
    .stop_bits(stop_bits), .cts_n(cts_n), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: list the frame's bits, then stretch each to max(div,1) cycles
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                                      input logic pev, input logic sb, input int div,
                                      output logic [127:0] v, output int len);
    int bits[$];
    int ones;
    int nd;
    int dv;
    nd = int'(db) + 5;
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (pe) bits.push_back(pev ? (ones % 2) : 1 - (ones % 2));
    bits.push_back(1);
    if (sb) bits.push_back(1);
    dv = (div == 0) ? 1 : div;
    v = '0;
    len = 0;
    foreach (bits[k]) begin
      for (int r = 0; r < dv; r++) begin
        v[len] = (bits[k] != 0);
        len++;
      end
    end
  endfunction

  task automatic set_cfg(input int div, input logic [1:0] db, input logic pe, input logic pev, input logic sb);
    baud_div = 16'(div);
    data_bits = db;
    parity_en = pe;
    parity_even = pev;
    stop_bits = sb;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", n < 400, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic collect(input logic [127:0] ev, input int len, input string tag,
                         output int w, output logic r0);
    logic [127:0] got_tx;
    logic [127:0] got_busy;
    got_tx = '0;
    got_busy = '0;
    w = 0;
    while (uart_tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    r0 = tx_ready;
    for (int i = 0; i < len; i++) begin
      got_tx[i] = uart_tx;
      got_busy[i] = tx_busy;
      @(negedge clk);
    end
    check({tag, ":line"}, got_tx, ev);
    check({tag, ":busy"}, got_busy, (128'd1 << len) - 128'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input string tag, input bit scramble);
    logic [127:0] ev;
    int len;
    int w;
    logic r0;
    build_frame(d, data_bits, parity_en, parity_even, stop_bits, int'(baud_div), ev, len);
    fork
      push(d);
      collect(ev, len, tag, w, r0);
      begin
        if (scramble) begin
          int n;
          n = 0;
          while (uart_tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
          end
          @(negedge clk);
          set_cfg($urandom_range(0, 6), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
    join
    check({tag, ":start_lat"}, w, 2);
    check({tag, ":idle_after"}, {uart_tx, tx_busy, tx_ready}, 3'b101);
  endtask

  initial begin
    logic [127:0] e1;
    logic [127:0] e2;
    int l1;
    int l2;
    int w1;
    int w2;
    logic r1;
    logic r2;
    int lows;
    int rdy_lows;
    int n;

    repeat (3) @(negedge clk);
    check("reset_outputs", {uart_tx, tx_ready, tx_busy}, 3'b110);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_idle", {uart_tx, tx_ready, tx_busy}, 3'b110);

    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, "8n1_55", 1'b0);

    set_cfg(2, 2'b10, 1'b1, 1'b1, 1'b1);
    send_frame(8'h03, "7e2_03", 1'b0);

    set_cfg(0, 2'b11, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, "div0_ff", 1'b0);

    set_cfg(3, 2'b11, 1'b0, 1'b0, 1'b0);
    build_frame(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 3, e1, l1);
    build_frame(8'h34, 2'b11, 1'b0, 1'b0, 1'b0, 3, e2, l2);
    fork
      begin
        push(8'h12);
        push(8'h34);
      end
      begin
        collect(e1, l1, "b2b_first", w1, r1);
        collect(e2, l2, "b2b_second", w2, r2);
      end
    join
    check("b2b_first_lat", w1, 2);
    check("b2b_ready_after_load", r1, 1'b1);
    check("b2b_gap", w2, 0);
    check("b2b_idle_after", {uart_tx, tx_busy, tx_ready}, 3'b101);

`ifdef UART_TX_CTS_FLOW_EN
    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    push(8'hA5);
    lows = 0;
    rdy_lows = 0;
    repeat (20) begin
      if (uart_tx !== 1'b1) lows++;
      if (tx_ready !== 1'b0) rdy_lows++;
      @(negedge clk);
    end
    check("cts_block_line", lows, 0);
    check("cts_block_ready", rdy_lows, 0);
    build_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 4, e1, l1);
    cts_n = 1'b0;
    fork
      collect(e1, l1, "cts_frame", w1, r1);
      begin
        repeat (SYNC + 6) @(negedge clk);
        cts_n = 1'b1;
      end
    join
    check("cts_start_lat", w1, SYNC + 1);
    check("cts_idle_after", {uart_tx, tx_busy, tx_ready}, 3'b101);
    cts_n = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
`else
    set_cfg(2, 2'b01, 1'b1, 1'b0, 1'b0);
    cts_n = 1'b1;
    send_frame(8'hA5, "cts_ignored", 1'b0);
    cts_n = 1'b0;
`endif

    for (int it = 0; it < 12; it++) begin
      set_cfg($urandom_range(0, 6), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      send_frame(8'($urandom), $sformatf("rand%0d", it), 1'b1);
    end

    set_cfg(4, 2'b11, 1'b0, 1'b0, 1'b0);
    fork
      begin
        push(8'h00);
        push(8'h5A);
      end
      begin
        n = 0;
        while (uart_tx !== 1'b0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        repeat (12) @(negedge clk);
        check("pre_reset_state", {uart_tx, tx_ready, tx_busy}, 3'b001);
        #2 reset = 1'b1;
        #1 check("reset_midframe", {uart_tx, tx_ready, tx_busy}, 3'b110);
      end
    join
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (60) begin
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      @(negedge clk);
    end
    check("buffer_discarded", lows, 0);
    check("ready_after_reset", tx_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
